// File: rtl/multi_com_tracker.sv
// multi_com_tracker: inline multi-class colour-threshold tracker on a 24-bit video stream.
// Each class has its own RGB window, saturating centre-of-mass accumulators, latched
// per-frame results and an overlay colour. Thresholds are shadowed and go live on video sop.
module multi_com_tracker #(
    parameter int unsigned NUM_CLASSES = 4,
    parameter int unsigned IMAGE_W     = 640,
    parameter int unsigned IMAGE_H     = 480,
    parameter int unsigned ACC_W       = 32,
    parameter int unsigned MIN_MASS    = 16,
    parameter logic [31:0] ID_VALUE    = 32'h1234EEE3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s_chipselect,
    input  logic        s_read,
    input  logic        s_write,
    input  logic [5:0]  s_address,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    input  logic [23:0] sink_data,
    input  logic        sink_valid,
    output logic        sink_ready,
    input  logic        sink_sop,
    input  logic        sink_eop,
    output logic [23:0] source_data,
    output logic        source_valid,
    input  logic        source_ready,
    output logic        source_sop,
    output logic        source_eop,
    output logic        irq
);

    localparam int unsigned XW = (IMAGE_W > 1) ? $clog2(IMAGE_W) : 1;
    localparam int unsigned YW = (IMAGE_H > 1) ? $clog2(IMAGE_H) : 1;
    localparam logic [XW-1:0] XMax = XW'(IMAGE_W - 1);
    localparam logic [YW-1:0] YMax = YW'(IMAGE_H - 1);
    localparam logic [ACC_W-1:0] MinMass = ACC_W'(MIN_MASS);

    typedef enum logic [1:0] {StWait, StVideo, StOther} state_e;

    // Saturating unsigned add at the accumulator width.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
    endfunction

    // Inclusive per-component window test.
    function automatic logic in_window(input logic [23:0] p, input logic [23:0] lo,
                                       input logic [23:0] hi);
        return (p[23:16] >= lo[23:16]) && (p[23:16] <= hi[23:16]) &&
               (p[15:8] >= lo[15:8]) && (p[15:8] <= hi[15:8]) &&
               (p[7:0] >= lo[7:0]) && (p[7:0] <= hi[7:0]);
    endfunction

    // Stream and packet tracking
    state_e      state_q, state_d;
    logic        beat_acc, hdr_video, sop_video, video_beat, video_eop;
    logic [23:0] out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d, out_sop_q, out_sop_d, out_eop_q, out_eop_d;
    logic [23:0] pix_out;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    // Register file
    logic [2:0]  ctrl_q, ctrl_d;
    logic        done_q, done_d;
    logic [7:0]  fcnt_q, fcnt_d;
    logic [31:0] rdata_q, rdata_d, rd_mux;
    logic        mm_wr;

    // Per-class state: pending/active windows and colours, accumulators, results
    logic [23:0] low_p_q [NUM_CLASSES];
    logic [23:0] low_p_d [NUM_CLASSES];
    logic [23:0] up_p_q  [NUM_CLASSES];
    logic [23:0] up_p_d  [NUM_CLASSES];
    logic [23:0] col_p_q [NUM_CLASSES];
    logic [23:0] col_p_d [NUM_CLASSES];
    logic [23:0] low_a_q [NUM_CLASSES];
    logic [23:0] low_a_d [NUM_CLASSES];
    logic [23:0] up_a_q  [NUM_CLASSES];
    logic [23:0] up_a_d  [NUM_CLASSES];
    logic [23:0] col_a_q [NUM_CLASSES];
    logic [23:0] col_a_d [NUM_CLASSES];
    logic [ACC_W-1:0] mass_q [NUM_CLASSES];
    logic [ACC_W-1:0] mass_d [NUM_CLASSES];
    logic [ACC_W-1:0] sumx_q [NUM_CLASSES];
    logic [ACC_W-1:0] sumx_d [NUM_CLASSES];
    logic [ACC_W-1:0] sumy_q [NUM_CLASSES];
    logic [ACC_W-1:0] sumy_d [NUM_CLASSES];
    logic [ACC_W-1:0] rmass_q [NUM_CLASSES];
    logic [ACC_W-1:0] rmass_d [NUM_CLASSES];
    logic [ACC_W-1:0] rsumx_q [NUM_CLASSES];
    logic [ACC_W-1:0] rsumx_d [NUM_CLASSES];
    logic [ACC_W-1:0] rsumy_q [NUM_CLASSES];
    logic [ACC_W-1:0] rsumy_d [NUM_CLASSES];
    logic [NUM_CLASSES-1:0] valid_q, valid_d, match;

    logic unused_wdata;
    assign unused_wdata = ^s_writedata[31:24];

    assign beat_acc  = sink_valid & sink_ready;
    assign hdr_video = (sink_data[3:0] == 4'h0);
    assign sop_video = beat_acc & sink_sop & hdr_video;
    assign mm_wr     = s_chipselect & s_write;

    assign sink_ready   = source_ready | ~out_valid_q;
    assign source_data  = out_data_q;
    assign source_valid = out_valid_q;
    assign source_sop   = out_sop_q;
    assign source_eop   = out_eop_q;
    assign s_readdata   = rdata_q;
    assign irq          = done_q & ctrl_q[2];

    // Packet state register; reset drops any partial frame until the next sop
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= StWait;
        else          state_q <= state_d;
    end

    // Packet next state: classify on sop, return to waiting after eop
    always_comb begin
        state_d = state_q;
        if (beat_acc) begin
            if (sink_eop)      state_d = StWait;
            else if (sink_sop) state_d = hdr_video ? StVideo : StOther;
        end
    end

    // Packet outputs: pixel beats and frame end of video packets only
    always_comb begin
        video_beat = beat_acc && !sink_sop && (state_q == StVideo);
        video_eop  = beat_acc && sink_eop && (sink_sop ? hdr_video : (state_q == StVideo));
    end

    // Per-class window match against the active (frame-stable) thresholds
    always_comb begin
        match = '0;
        for (int k = 0; k < int'(NUM_CLASSES); k++) begin
            match[k] = in_window(sink_data, low_a_q[k], up_a_q[k]);
        end
    end

    // Overlay: lowest-index matching class wins, so scan from the top down
    always_comb begin
        pix_out = sink_data;
        if (video_beat && ctrl_q[1]) begin
            for (int k = int'(NUM_CLASSES) - 1; k >= 0; k--) begin
                if (match[k]) pix_out = col_a_q[k];
            end
        end
    end

    // Output stage next state: load on transfer, drop valid once consumed
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        if (beat_acc) begin
            out_data_d  = pix_out;
            out_valid_d = 1'b1;
            out_sop_d   = sink_sop;
            out_eop_d   = sink_eop;
        end else if (source_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output stage register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
        end
    end

    // Pixel coordinates: x wraps per line, y sticks at the last line
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (beat_acc && sink_sop) begin
            x_d = '0;
            y_d = '0;
        end else if (video_beat) begin
            if (x_q == XMax) begin
                x_d = '0;
                if (y_q != YMax) y_d = y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    // Coordinate register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    // MM writes to CTRL/pending registers, STATUS update (set beats W1C), window shadowing
    always_comb begin
        ctrl_d  = ctrl_q;
        done_d  = done_q;
        fcnt_d  = fcnt_q;
        low_p_d = low_p_q;
        up_p_d  = up_p_q;
        col_p_d = col_p_q;
        low_a_d = low_a_q;
        up_a_d  = up_a_q;
        col_a_d = col_a_q;
        if (mm_wr) begin
            if (s_address == 6'd1) ctrl_d = s_writedata[2:0];
            if (s_address == 6'd2 && s_writedata[0]) done_d = 1'b0;
            for (int k = 0; k < int'(NUM_CLASSES); k++) begin
                if (s_address[5:3] == 3'(k + 1)) begin
                    case (s_address[2:0])
                        3'd0:    low_p_d[k] = s_writedata[23:0];
                        3'd1:    up_p_d[k]  = s_writedata[23:0];
                        3'd2:    col_p_d[k] = s_writedata[23:0];
                        default: ;
                    endcase
                end
            end
        end
        if (video_eop) begin
            done_d = 1'b1;
            fcnt_d = fcnt_q + 8'd1;
        end
        if (sop_video) begin
            low_a_d = low_p_q;
            up_a_d  = up_p_q;
            col_a_d = col_p_q;
        end
    end

    // Register file and window registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ctrl_q  <= '0;
            done_q  <= 1'b0;
            fcnt_q  <= '0;
            low_p_q <= '{default: '0};
            up_p_q  <= '{default: '0};
            col_p_q <= '{default: '0};
            low_a_q <= '{default: '0};
            up_a_q  <= '{default: '0};
            col_a_q <= '{default: '0};
        end else begin
            ctrl_q  <= ctrl_d;
            done_q  <= done_d;
            fcnt_q  <= fcnt_d;
            low_p_q <= low_p_d;
            up_p_q  <= up_p_d;
            col_p_q <= col_p_d;
            low_a_q <= low_a_d;
            up_a_q  <= up_a_d;
            col_a_q <= col_a_d;
        end
    end

    // Accumulate matching pixels; on frame end latch totals including the eop beat
    always_comb begin
        mass_d  = mass_q;
        sumx_d  = sumx_q;
        sumy_d  = sumy_q;
        rmass_d = rmass_q;
        rsumx_d = rsumx_q;
        rsumy_d = rsumy_q;
        valid_d = valid_q;
        for (int k = 0; k < int'(NUM_CLASSES); k++) begin
            if (sop_video) begin
                mass_d[k] = '0;
                sumx_d[k] = '0;
                sumy_d[k] = '0;
            end else if (video_beat && ctrl_q[0] && match[k]) begin
                mass_d[k] = sat_add(mass_q[k], ACC_W'(1));
                sumx_d[k] = sat_add(sumx_q[k], ACC_W'(x_q));
                sumy_d[k] = sat_add(sumy_q[k], ACC_W'(y_q));
            end
            if (video_eop) begin
                rmass_d[k] = mass_d[k];
                rsumx_d[k] = sumx_d[k];
                rsumy_d[k] = sumy_d[k];
                valid_d[k] = (mass_d[k] >= MinMass);
            end
        end
    end

    // Accumulator and result registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mass_q  <= '{default: '0};
            sumx_q  <= '{default: '0};
            sumy_q  <= '{default: '0};
            rmass_q <= '{default: '0};
            rsumx_q <= '{default: '0};
            rsumy_q <= '{default: '0};
            valid_q <= '0;
        end else begin
            mass_q  <= mass_d;
            sumx_q  <= sumx_d;
            sumy_q  <= sumy_d;
            rmass_q <= rmass_d;
            rsumx_q <= rsumx_d;
            rsumy_q <= rsumy_d;
            valid_q <= valid_d;
        end
    end

    // Read decode; anything unmapped returns zero
    always_comb begin
        rd_mux = '0;
        if (s_address == 6'd0)      rd_mux = ID_VALUE;
        else if (s_address == 6'd1) rd_mux = {29'd0, ctrl_q};
        else if (s_address == 6'd2) rd_mux = {16'd0, fcnt_q, 7'd0, done_q};
        for (int k = 0; k < int'(NUM_CLASSES); k++) begin
            if (s_address[5:3] == 3'(k + 1)) begin
                case (s_address[2:0])
                    3'd0:    rd_mux = {8'd0, low_p_q[k]};
                    3'd1:    rd_mux = {8'd0, up_p_q[k]};
                    3'd2:    rd_mux = {8'd0, col_p_q[k]};
                    3'd3:    rd_mux = 32'(rmass_q[k]);
                    3'd4:    rd_mux = 32'(rsumx_q[k]);
                    3'd5:    rd_mux = 32'(rsumy_q[k]);
                    3'd6:    rd_mux = {31'd0, valid_q[k]};
                    default: rd_mux = '0;
                endcase
            end
        end
        rdata_d = (s_chipselect && s_read) ? rd_mux : rdata_q;
    end

    // Registered read data
    always_ff @(posedge clk) begin
        if (!reset_n) rdata_q <= '0;
        else          rdata_q <= rdata_d;
    end

endmodule

// File: tb/tb_multi_com_tracker.sv
// Bench for multi_com_tracker at a reduced frame size; a frame-level reference model
// predicts output beats and per-class results from the window rules directly.
module tb_multi_com_tracker;

    localparam int W = 40;
    localparam int H = 30;
    localparam int NC = 3;
    localparam int AW = 15;
    localparam int MINM = 16;
    localparam longint SatMax = (64'd1 << AW) - 1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        s_chipselect, s_read, s_write;
    logic [5:0]  s_address;
    logic [31:0] s_writedata, s_readdata;
    logic [23:0] sink_data, source_data;
    logic        sink_valid, sink_ready, sink_sop, sink_eop;
    logic        source_valid, source_ready, source_sop, source_eop, irq;

    always #5 clk = ~clk;

    multi_com_tracker #(
        .NUM_CLASSES(NC),
        .IMAGE_W    (W),
        .IMAGE_H    (H),
        .ACC_W      (AW),
        .MIN_MASS   (MINM)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .s_chipselect(s_chipselect),
        .s_read      (s_read),
        .s_write     (s_write),
        .s_address   (s_address),
        .s_writedata (s_writedata),
        .s_readdata  (s_readdata),
        .sink_data   (sink_data),
        .sink_valid  (sink_valid),
        .sink_ready  (sink_ready),
        .sink_sop    (sink_sop),
        .sink_eop    (sink_eop),
        .source_data (source_data),
        .source_valid(source_valid),
        .source_ready(source_ready),
        .source_sop  (source_sop),
        .source_eop  (source_eop),
        .irq         (irq)
    );

    int n_vec = 0;
    int n_err = 0;
    logic bp_en = 1'b0;
    logic [25:0] got[$], exp_q[$], prev[$];
    logic [23:0] pix[$];
    logic [23:0] m_low[NC], m_up[NC], m_col[NC], a_low[NC], a_up[NC], a_col[NC];
    logic [2:0]  m_ctrl;
    logic        m_done;
    logic [7:0]  m_cnt;
    longint      r_mass[NC], r_sumx[NC], r_sumy[NC];
    logic        r_valid[NC];

    // Capture every output beat that transfers on the following edge
    always @(negedge clk) begin
        if (reset_n && source_valid && source_ready)
            got.push_back({source_sop, source_eop, source_data});
    end

    // Downstream readiness, randomly throttled when backpressure is enabled
    initial begin
        source_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            source_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic in_win(input logic [23:0] p, input logic [23:0] lo,
                                    input logic [23:0] hi);
        for (int c = 0; c < 3; c++) begin
            int v, l, u;
            v = int'(p[c*8 +: 8]);
            l = int'(lo[c*8 +: 8]);
            u = int'(hi[c*8 +: 8]);
            if (v < l || v > u) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < NC; k++) begin
            m_low[k] = '0; m_up[k] = '0; m_col[k] = '0;
            r_mass[k] = 0; r_sumx[k] = 0; r_sumy[k] = 0; r_valid[k] = 1'b0;
        end
        m_ctrl = '0; m_done = 1'b0; m_cnt = '0;
    endfunction

    function automatic void model_write(input logic [5:0] a, input logic [31:0] d);
        int k;
        if (a == 6'd1) m_ctrl = d[2:0];
        if (a == 6'd2 && d[0]) m_done = 1'b0;
        k = int'(a[5:3]) - 1;
        if (k >= 0 && k < NC) begin
            if (a[2:0] == 3'd0) m_low[k] = d[23:0];
            if (a[2:0] == 3'd1) m_up[k] = d[23:0];
            if (a[2:0] == 3'd2) m_col[k] = d[23:0];
        end
    endfunction

    task automatic mm_write(input logic [5:0] a, input logic [31:0] d);
        s_chipselect = 1'b1; s_write = 1'b1; s_address = a; s_writedata = d;
        @(posedge clk);
        #1;
        s_chipselect = 1'b0; s_write = 1'b0;
    endtask

    task automatic reg_write(input logic [5:0] a, input logic [31:0] d);
        mm_write(a, d);
        model_write(a, d);
    endtask

    task automatic mm_read(input logic [5:0] a, output logic [31:0] d);
        s_chipselect = 1'b1; s_read = 1'b1; s_address = a;
        @(posedge clk);
        #1;
        s_chipselect = 1'b0; s_read = 1'b0;
        d = s_readdata;
    endtask

    task automatic check_reg(input string tag, input logic [5:0] a, input logic [31:0] expv);
        logic [31:0] d;
        mm_read(a, d);
        check(tag, d, expv);
    endtask

    task automatic check_class(input int k, input string tag);
        logic [5:0] b;
        b = 6'(8 * (k + 1));
        check_reg($sformatf("%s mass%0d", tag, k), b + 6'd3, 32'(r_mass[k]));
        check_reg($sformatf("%s sumx%0d", tag, k), b + 6'd4, 32'(r_sumx[k]));
        check_reg($sformatf("%s sumy%0d", tag, k), b + 6'd5, 32'(r_sumy[k]));
        check_reg($sformatf("%s valid%0d", tag, k), b + 6'd6, {31'd0, r_valid[k]});
    endtask

    task automatic check_status(input string tag);
        check_reg(tag, 6'd2, {16'd0, m_cnt, 7'd0, m_done});
    endtask

    task automatic send_beat(input logic [23:0] d, input logic sop, input logic eop);
        int t;
        t = 0;
        sink_data = d; sink_sop = sop; sink_eop = eop; sink_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (sink_ready) break;
            t++;
            if (t > 1000) begin
                check("sink_ready timeout", {31'd0, sink_ready}, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Predict one packet from pix[], send it (optionally with an MM write mid-packet), compare.
    task automatic run_frame(input logic [23:0] hdr, input int mid_idx, input logic [5:0] mid_a,
                             input logic [31:0] mid_d, input string tag);
        logic   video;
        longint ms[NC], sx[NC], sy[NC];
        int     t, last;
        repeat (2) @(posedge clk);
        #1;
        got.delete();
        exp_q.delete();
        video = (hdr[3:0] == 4'h0);
        last = pix.size() - 1;
        if (video) begin
            for (int k = 0; k < NC; k++) begin
                a_low[k] = m_low[k]; a_up[k] = m_up[k]; a_col[k] = m_col[k];
            end
        end
        for (int k = 0; k < NC; k++) begin
            ms[k] = 0; sx[k] = 0; sy[k] = 0;
        end
        exp_q.push_back({1'b1, 1'b0, hdr});
        for (int i = 0; i <= last; i++) begin
            int x, line, y, first;
            logic [23:0] o;
            x = i % W;
            line = i / W;
            y = (line > H - 1) ? H - 1 : line;
            o = pix[i];
            first = -1;
            if (video) begin
                for (int k = 0; k < NC; k++) begin
                    if (in_win(pix[i], a_low[k], a_up[k])) begin
                        if (first < 0) first = k;
                        if (m_ctrl[0]) begin
                            ms[k] += 1; sx[k] += x; sy[k] += y;
                        end
                    end
                end
                if (m_ctrl[1] && first >= 0) o = a_col[first];
            end
            exp_q.push_back({1'b0, (i == last), o});
        end
        if (video) begin
            for (int k = 0; k < NC; k++) begin
                r_mass[k] = (ms[k] > SatMax) ? SatMax : ms[k];
                r_sumx[k] = (sx[k] > SatMax) ? SatMax : sx[k];
                r_sumy[k] = (sy[k] > SatMax) ? SatMax : sy[k];
                r_valid[k] = (r_mass[k] >= MINM);
            end
            m_done = 1'b1;
            m_cnt = m_cnt + 8'd1;
        end
        send_beat(hdr, 1'b1, 1'b0);
        for (int i = 0; i <= last; i++) begin
            if (i == mid_idx) begin
                sink_valid = 1'b0;
                reg_write(mid_a, mid_d);
            end
            send_beat(pix[i], 1'b0, (i == last));
        end
        sink_valid = 1'b0;
        t = 0;
        while (got.size() < exp_q.size() && t < 5000) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        check($sformatf("%s beat count", tag), got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s beat%0d", tag, i),
                  (i < got.size()) ? 32'(got[i]) : 32'hxxxxxxxx, 32'(exp_q[i]));
        end
    endtask

    function automatic logic [23:0] rand_hdr();
        return {20'($urandom), 4'h0};
    endfunction

    initial begin
        logic [23:0] hdr;
        reset_n = 1'b0;
        s_chipselect = 1'b0; s_read = 1'b0; s_write = 1'b0; s_address = '0; s_writedata = '0;
        sink_data = '0; sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst readdata", s_readdata, 32'd0);
        check("rst source_valid", {31'd0, source_valid}, 32'd0);
        check("rst source_sop", {31'd0, source_sop}, 32'd0);
        check("rst source_eop", {31'd0, source_eop}, 32'd0);
        check("rst irq", {31'd0, irq}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_reg("id", 6'd0, 32'h1234EEE3);
        check_reg("rst ctrl", 6'd1, 32'd0);
        check_status("rst status");
        check_class(0, "rst");

        // Partial frame interrupted by reset
        reg_write(6'd8, 32'hC80000);
        reg_write(6'd9, 32'hFF3232);
        reg_write(6'd1, 32'd1);
        send_beat(rand_hdr(), 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) send_beat(24'hFF0000, 1'b0, 1'b0);
        sink_valid = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        check("rst2 source_valid", {31'd0, source_valid}, 32'd0);
        check_status("rst2 status");
        check_class(0, "rst2");
        check_reg("rst2 thr_low0", 6'd8, 32'd0);

        // Stray beats before any sop, then a full red frame
        reg_write(6'd8, 32'hC80000);
        reg_write(6'd9, 32'hFF3232);
        reg_write(6'd1, 32'd1);
        for (int i = 0; i < 5; i++) send_beat(24'hFF0000, 1'b0, 1'b0);
        sink_valid = 1'b0;
        pix.delete();
        for (int i = 0; i < W * H; i++) pix.push_back(24'hFF0000);
        run_frame(rand_hdr(), -1, 6'd0, 32'd0, "full");
        check_class(0, "full");
        check_reg("full mass const", 6'd11, 32'(W * H));
        check_status("full status");

        // 4x4 then 3x3 red block on a background that never reaches class0's red range
        for (int sz = 4; sz >= 3; sz--) begin
            pix.delete();
            for (int i = 0; i < W * H; i++) pix.push_back({1'b0, 7'($urandom), 16'($urandom)});
            for (int y = 5; y < 5 + sz; y++)
                for (int x = 10; x < 10 + sz; x++) pix[y * W + x] = 24'hFF0000;
            run_frame(rand_hdr(), -1, 6'd0, 32'd0, $sformatf("block%0d", sz));
            check_class(0, $sformatf("block%0d", sz));
        end

        // Overlapping windows with overlay; then the same frame under backpressure
        reg_write(6'd8, 32'h404040); reg_write(6'd9, 32'hC0C0C0); reg_write(6'd10, 32'h00FF00);
        reg_write(6'd16, 32'h202020); reg_write(6'd17, 32'hA0A0A0); reg_write(6'd18, 32'h0000FF);
        reg_write(6'd24, 32'h000000); reg_write(6'd25, 32'h3F3F3F); reg_write(6'd26, 32'hFF00FF);
        reg_write(6'd1, 32'd3);
        pix.delete();
        for (int i = 0; i < W * H; i++) pix.push_back(24'($urandom));
        hdr = rand_hdr();
        run_frame(hdr, -1, 6'd0, 32'd0, "ovl");
        for (int k = 0; k < NC; k++) check_class(k, "ovl");
        prev = got;
        bp_en = 1'b1;
        run_frame(hdr, -1, 6'd0, 32'd0, "bp");
        bp_en = 1'b0;
        check("bp vs nobp count", got.size(), prev.size());
        for (int i = 0; i < prev.size() && i < got.size(); i++)
            check($sformatf("bp vs nobp beat%0d", i), 32'(got[i]), 32'(prev[i]));
        check_class(1, "bp");

        // Threshold rewritten mid-frame takes effect only from the next frame
        reg_write(6'd1, 32'd1);
        reg_write(6'd8, 32'h800000);
        reg_write(6'd9, 32'hFF3232);
        pix.delete();
        for (int i = 0; i < W * H; i++)
            pix.push_back({8'($urandom), 8'($urandom_range(0, 50)), 8'($urandom_range(0, 50))});
        run_frame(rand_hdr(), W * H / 2, 6'd8, 32'hE00000, "mid old");
        check_class(0, "mid old");
        check_reg("mid pending", 6'd8, 32'hE00000);
        run_frame(rand_hdr(), -1, 6'd0, 32'd0, "mid new");
        check_class(0, "mid new");

        // Over-tall frame: y sticks at the last line, sums saturate
        pix.delete();
        for (int i = 0; i < W * H * 2; i++) pix.push_back(24'hFF0000);
        run_frame(rand_hdr(), -1, 6'd0, 32'd0, "sat");
        check_class(0, "sat");
        check_reg("sat sumx const", 6'd12, 32'(SatMax));

        // Non-video packet leaves results and irq alone; short video frame raises irq
        reg_write(6'd2, 32'd1);
        reg_write(6'd1, 32'd7);
        check("irq idle", {31'd0, irq}, 32'd0);
        pix.delete();
        for (int i = 0; i < 30; i++) pix.push_back((i % 2) ? 24'hFF0000 : 24'($urandom));
        run_frame({20'($urandom), 4'hF}, -1, 6'd0, 32'd0, "nonvideo");
        check("irq after nonvideo", {31'd0, irq}, 32'd0);
        check_status("nonvideo status");
        check_class(0, "nonvideo");
        pix.delete();
        for (int i = 0; i < 50; i++) pix.push_back((i % 3) ? 24'hFF0000 : 24'($urandom));
        run_frame(rand_hdr(), -1, 6'd0, 32'd0, "short");
        check("irq after video", {31'd0, irq}, 32'd1);
        check_status("short status");
        check_class(0, "short");
        reg_write(6'd2, 32'd1);
        check("irq after w1c", {31'd0, irq}, 32'd0);
        check_status("w1c status");

        // Unmapped and out-of-range addresses
        check_reg("unmapped 5", 6'd5, 32'd0);
        check_reg("class0 +7", 6'd15, 32'd0);
        check_reg("class3 base", 6'd32, 32'd0);
        mm_write(6'd33, 32'h00ABCDEF);
        check_reg("class3 write", 6'd33, 32'd0);
        check_reg("class1 up", 6'd17, {8'd0, m_up[1]});
        check_reg("ctrl rb", 6'd1, {29'd0, m_ctrl});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
